// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding and slice width for the sequential CLA adder.
package cla_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int SLICE_W = 8;
endpackage

// File: rtl/cla_seq_adder_cla8.sv
// cla8: 8-bit carry-lookahead slice; generate/propagate terms feed the carry chain.
module cla8 (
    input  logic [7:0] i_x,
    input  logic [7:0] i_y,
    input  logic       i_c,
    output logic [7:0] o_s,
    output logic       o_c
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;
    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;
    // the recurrence flattens into per-bit lookahead product terms
    always_comb begin
        w_c[0] = i_c;
        for (int i = 0; i < 8; i++) w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
    assign o_s = w_p ^ w_c[7:0];
    assign o_c = w_c[8];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit add over WIDTH/8 cycles through one shared CLA8 slice, LSB byte first.
// Define CLA_SEQ_SUB_EN to add a sub input that turns the operation into x - y.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] s,
    output logic             cOut,
    output logic             ovf
);
    localparam int NBYTE = WIDTH / SLICE_W;
    localparam int CNT_W = $clog2(NBYTE + 1);

    if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a multiple of 8 and at least 8");
    end

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_x, r_y, r_s;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry, r_xmsb, r_ymsb;
    logic [WIDTH-1:0]   w_y_in;
    logic               w_c_in, w_accept, w_last, w_c8;
    logic [SLICE_W-1:0] w_sum8;

`ifdef CLA_SEQ_SUB_EN
    assign w_y_in = sub ? ~y : y;
    assign w_c_in = sub | cIn;
`else
    assign w_y_in = y;
    assign w_c_in = cIn;
`endif

    assign w_accept = inValid && inReady;
    assign w_last   = r_cnt == CNT_W'(NBYTE - 1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        inReady  = 1'b0;
        outValid = 1'b0;
        unique case (r_state)
            IDLE: begin
                inReady = 1'b1;
                w_next  = inValid ? RUN : IDLE;
            end
            RUN:  w_next = w_last ? DONE : RUN;
            DONE: begin
                outValid = 1'b1;
                w_next   = outReady ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    cla8 u_cla8 (
        .i_x (r_x[SLICE_W-1:0]),
        .i_y (r_y[SLICE_W-1:0]),
        .i_c (r_carry),
        .o_s (w_sum8),
        .o_c (w_c8)
    );

    // sum bytes enter at the top so the LSB byte lands at bit 0 after NBYTE shifts
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_xmsb  <= 1'b0;
            r_ymsb  <= 1'b0;
        end else if (w_accept) begin
            r_x     <= x;
            r_y     <= w_y_in;
            r_carry <= w_c_in;
            r_xmsb  <= x[WIDTH-1];
            r_ymsb  <= w_y_in[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_s     <= (r_s >> SLICE_W) | (WIDTH'(w_sum8) << (WIDTH - SLICE_W));
            r_x     <= r_x >> SLICE_W;
            r_y     <= r_y >> SLICE_W;
            r_carry <= w_c8;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign s    = r_s;
    assign cOut = r_carry;
    assign ovf  = (r_xmsb == r_ymsb) && (r_s[WIDTH-1] != r_xmsb);
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: self-checking bench for cla_seq_adder at WIDTH=32.
module tb_cla_seq_adder;
    localparam int WIDTH = 32;
    localparam int NBYTE = WIDTH / 8;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
        int               t;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             ci;
        logic             sb;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
    } vec_t;

    logic             clk, rstN, inValid, inReady, cIn, outValid, outReady, cOut, ovf, sub;
    logic [WIDTH-1:0] x, y, s;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;
    bit   seen = 0;
    bit   prev_hs = 0;
    exp_t q[$];
    exp_t exp_cur;
    vec_t tbl[$];

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
`ifdef CLA_SEQ_SUB_EN
        .sub      (sub),
`endif
        .x        (x),
        .y        (y),
        .cIn      (cIn),
        .outValid (outValid),
        .outReady (outReady),
        .s        (s),
        .cOut     (cOut),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic sb);
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] bb;
        bb = sb ? ~b : b;
        t = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sb | ci);
        model.s   = t[WIDTH-1:0];
        model.c   = t[WIDTH];
        model.ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        model.t   = 0;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic cyc(output bit acc);
        bit   hs;
        exp_t e;
        acc = rstN && inValid && inReady;
        hs  = rstN && outValid && outReady;
        if (prev_hs) begin
            chk("valid_drop", WIDTH'(outValid), '0);
            chk("ready_after_hs", WIDTH'(inReady), WIDTH'(1));
        end
        if (acc) begin
            e   = exp_cur;
            e.t = n_cyc + 1;
            q.push_back(e);
        end
        if (rstN && outValid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_valid: outValid=1 with nothing outstanding, required 0");
            end else begin
                e = q[0];
                if (!seen) begin
                    chk("latency_edge", WIDTH'(n_cyc), WIDTH'(e.t + NBYTE));
                    seen = 1;
                end
                chk("s", s, e.s);
                chk("cOut", WIDTH'(cOut), WIDTH'(e.c));
                chk("ovf", WIDTH'(ovf), WIDTH'(e.ovf));
                chk("inReady_busy", WIDTH'(inReady), '0);
                if (outReady) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
        prev_hs = hs;
        @(posedge clk);
        n_cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb, input exp_t e);
        bit acc = 0;
        exp_cur = e;
        inValid = 1;
        for (int i = 0; i < 40 && !acc; i++) begin
            if (inReady) begin
                x = a; y = b; cIn = ci; sub = sb;
            end else begin
                x = $urandom; y = $urandom; cIn = 1'($urandom); sub = 1'($urandom);
            end
            cyc(acc);
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: request not accepted, required acceptance");
        end
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && q.size() != 0; i++) cyc(acc);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
            q.delete();
            seen = 0;
        end
    endtask

    initial begin
        bit acc;
        clk = 0; rstN = 0; inValid = 0; outReady = 1; x = '0; y = '0; cIn = 0; sub = 0;
        tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        tbl.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        tbl.push_back('{32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0});
        tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
        tbl.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
        tbl.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0});
        tbl.push_back('{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0});
        tbl.push_back('{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
`ifdef CLA_SEQ_SUB_EN
        tbl.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
        tbl.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
        tbl.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif
        #2;
        chk("rst_inReady", WIDTH'(inReady), WIDTH'(1));
        chk("rst_outValid", WIDTH'(outValid), '0);
        chk("rst_s", s, '0);
        chk("rst_cOut", WIDTH'(cOut), '0);
        chk("rst_ovf", WIDTH'(ovf), '0);
        @(negedge clk);
        rstN = 1;

        foreach (tbl[i]) begin
            send(tbl[i].x, tbl[i].y, tbl[i].ci, tbl[i].sb, '{s: tbl[i].s, c: tbl[i].c, ovf: tbl[i].ovf, t: 0});
            inValid = 0;
            drain();
        end

        // backpressure: result must hold for 10 stalled cycles
        outReady = 0;
        send(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, model(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0));
        inValid = 0;
        for (int i = 0; i < 20 && !outValid; i++) cyc(acc);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", WIDTH'(outValid), WIDTH'(1));
            cyc(acc);
        end
        outReady = 1;
        drain();
        cyc(acc);

        // reset two RUN cycles in, with a carry pending between bytes
        send(32'h0000_FFF0, 32'h0000_0020, 1'b0, 1'b0, model(32'h0000_FFF0, 32'h0000_0020, 1'b0, 1'b0));
        inValid = 0;
        cyc(acc);
        cyc(acc);
        rstN = 0;
        #1;
        chk("abort_outValid", WIDTH'(outValid), '0);
        chk("abort_inReady", WIDTH'(inReady), WIDTH'(1));
        chk("abort_s", s, '0);
        chk("abort_cOut", WIDTH'(cOut), '0);
        q.delete();
        seen = 0;
        prev_hs = 0;
        cyc(acc);
        rstN = 1;
        send('0, '0, 1'b0, 1'b0, '{s: '0, c: 1'b0, ovf: 1'b0, t: 0});
        inValid = 0;
        drain();

        // back-to-back with inValid held high and operands scrambled while busy
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, model(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0));
        send(32'hFFFF_0000, 32'h0001_0000, 1'b1, 1'b0, model(32'hFFFF_0000, 32'h0001_0000, 1'b1, 1'b0));
        send(32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, model(32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0));
        inValid = 0;
        drain();
        cyc(acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
